// File: rtl/exception_ctrl_pkg.sv
// Shared types and defaults for the exception controller.
//   exc_state_t : controller states (IDLE -> COMMIT -> FLUSH -> REDIRECT).
//   exc_kind_t  : 3-bit event kind, listed in descending priority.
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'hBFC0_0380;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_FLUSH,
    ST_REDIRECT
  } exc_state_t;

  typedef enum logic [2:0] {
    KIND_INT,
    KIND_OVF,
    KIND_SYS,
    KIND_BRK,
    KIND_ADEL,
    KIND_ADES,
    KIND_ERET
  } exc_kind_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for MEM-stage events.
//   Inputs : int_pend and the decoded exception/eret flags.
//   Outputs: kind (highest-priority event), hit (any event present).
// Priority: int > overflow > syscall > break > adel > ades > eret, so an eret
// that shares an instruction with any exception is dropped.
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic      int_pend,
  input  logic      overflow,
  input  logic      syscall,
  input  logic      brk,
  input  logic      adel,
  input  logic      ades,
  input  logic      eret,
  output exc_kind_t kind,
  output logic      hit
);

  // NOTE: every output gets a default first so no path through the
  // if-chain leaves a value unassigned and infers a latch.
  always_comb begin
    hit  = 1'b1;
    kind = KIND_INT;
    if (int_pend)      kind = KIND_INT;
    else if (overflow) kind = KIND_OVF;
    else if (syscall)  kind = KIND_SYS;
    else if (brk)      kind = KIND_BRK;
    else if (adel)     kind = KIND_ADEL;
    else if (ades)     kind = KIND_ADES;
    else if (eret)     kind = KIND_ERET;
    else               hit  = 1'b0;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception / interrupt / ERET sequencer sitting next to CP0.
//   MEM-stage inputs : mem_valid_i, mem_pc_i, mem_delayslot_i, decoded events.
//   CP0 inputs       : cp0_status_i, cp0_cause_i, cp0_epc_i, timer_int_i.
//   CP0 outputs      : *_flag_o one-cycle pulses with exc_pc_o/exc_delayslot_o.
//   Pipeline outputs : stall_o, flush_o.
//   Fetch handshake  : redirect_valid_o/redirect_pc_o, redirect_ready_i.
// An accepted event walks COMMIT (flag pulse) -> FLUSH -> REDIRECT; the
// pipeline is stalled until the redirect is accepted.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_break_i,
  input  logic        mem_overflow_i,
  input  logic        mem_adel_i,
  input  logic        mem_ades_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        timer_int_i,
  output logic        syscall_flag_o,
  output logic        break_flag_o,
  output logic        overflow_flag_o,
  output logic        adel_flag_o,
  output logic        ades_flag_o,
  output logic        int_flag_o,
  output logic        eret_flag_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  // FLUSH state covers the flush cycles after the COMMIT cycle.
  localparam logic [3:0] FLUSH_EXTRA = 4'(FLUSH_CYCLES - 1);

  exc_state_t  state_q, state_d;
  exc_kind_t   kind_q, kind_hit;
  logic [31:0] pc_q, target_q;
  logic        ds_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        hit, accept, int_pend;
  logic [7:0]  ip_eff;

  // Timer interrupt shares IP[7] with the hardware line in Cause.
  assign ip_eff   = cp0_cause_i[15:8] | {timer_int_i, 7'b0};
  assign int_pend = cp0_status_i[0] & ~cp0_status_i[1] & |(ip_eff & cp0_status_i[15:8]);

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  exc_prio_enc u_prio (
    .int_pend (int_pend),
    .overflow (mem_overflow_i),
    .syscall  (mem_syscall_i),
    .brk      (mem_break_i),
    .adel     (mem_adel_i),
    .ades     (mem_ades_i),
    .eret     (mem_eret_i),
    .kind     (kind_hit),
    .hit      (hit)
  );

  // Events in any other state are ignored; pending interrupts simply stay
  // asserted in CP0 and are seen again at the next IDLE cycle.
  assign accept = (state_q == ST_IDLE) && mem_valid_i && hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_INT;
      pc_q     <= '0;
      ds_q     <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        kind_q   <= kind_hit;
        pc_q     <= mem_pc_i;
        ds_q     <= mem_delayslot_i;
        target_q <= (kind_hit == KIND_ERET) ? cp0_epc_i : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    syscall_flag_o   = 1'b0;
    break_flag_o     = 1'b0;
    overflow_flag_o  = 1'b0;
    adel_flag_o      = 1'b0;
    ades_flag_o      = 1'b0;
    int_flag_o       = 1'b0;
    eret_flag_o      = 1'b0;
    exc_pc_o         = '0;
    exc_delayslot_o  = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    stall_o          = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        flush_o         = 1'b1;
        exc_pc_o        = pc_q;
        exc_delayslot_o = ds_q;
        unique case (kind_q)
          KIND_INT:  int_flag_o      = 1'b1;
          KIND_OVF:  overflow_flag_o = 1'b1;
          KIND_SYS:  syscall_flag_o  = 1'b1;
          KIND_BRK:  break_flag_o    = 1'b1;
          KIND_ADEL: adel_flag_o     = 1'b1;
          KIND_ADES: ades_flag_o     = 1'b1;
          default:   eret_flag_o     = 1'b1;
        endcase
        if (FLUSH_EXTRA == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_EXTRA - 4'd1;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios followed by a
// randomized run compared against a cycle-age reference model.
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          F   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 0, mem_delayslot_i = 0;
  logic [31:0] mem_pc_i = 0;
  logic        mem_syscall_i = 0, mem_break_i = 0, mem_overflow_i = 0;
  logic        mem_adel_i = 0, mem_ades_i = 0, mem_eret_i = 0;
  logic [31:0] cp0_status_i = 0, cp0_cause_i = 0, cp0_epc_i = 0;
  logic        timer_int_i = 0;
  logic        syscall_flag_o, break_flag_o, overflow_flag_o, adel_flag_o;
  logic        ades_flag_o, int_flag_o, eret_flag_o;
  logic [31:0] exc_pc_o, redirect_pc_o;
  logic        exc_delayslot_o, stall_o, flush_o, redirect_valid_o;
  logic        redirect_ready_i = 1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_delayslot_i(mem_delayslot_i),
    .mem_syscall_i(mem_syscall_i), .mem_break_i(mem_break_i),
    .mem_overflow_i(mem_overflow_i), .mem_adel_i(mem_adel_i), .mem_ades_i(mem_ades_i),
    .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .timer_int_i(timer_int_i),
    .syscall_flag_o(syscall_flag_o), .break_flag_o(break_flag_o),
    .overflow_flag_o(overflow_flag_o), .adel_flag_o(adel_flag_o),
    .ades_flag_o(ades_flag_o), .int_flag_o(int_flag_o), .eret_flag_o(eret_flag_o),
    .exc_pc_o(exc_pc_o), .exc_delayslot_o(exc_delayslot_o), .stall_o(stall_o),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i)
  );

  // Flags in priority order: int, ovf, sys, brk, adel, ades, eret.
  function automatic logic [6:0] flags();
    return {int_flag_o, overflow_flag_o, syscall_flag_o, break_flag_o,
            adel_flag_o, ades_flag_o, eret_flag_o};
  endfunction

  function automatic logic [74:0] all_outs();
    return {flags(), exc_pc_o, exc_delayslot_o, stall_o, flush_o,
            redirect_valid_o, redirect_pc_o};
  endfunction

  // Advance one clock; inputs are driven and outputs read 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i = 0; mem_pc_i = 0; mem_delayslot_i = 0;
    mem_syscall_i = 0; mem_break_i = 0; mem_overflow_i = 0;
    mem_adel_i = 0; mem_ades_i = 0; mem_eret_i = 0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0; timer_int_i = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (stall_o && n < 20) begin cyc(); n++; end
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL %s_idle_timeout: stall=%b required 0", name, stall_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs(); redirect_ready_i = 1; rst = 1;
    cyc(); cyc();
    checks++;
    if (all_outs() !== 75'd0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    rst = 0;
    cyc();
    checks++;
    if (all_outs() !== 75'd0) begin
      failures++; $display("FAIL idle_outputs: got %h required 0", all_outs());
    end
  endtask

  task automatic test_syscall();
    mem_valid_i = 1; mem_syscall_i = 1; mem_pc_i = 32'h8000_1000;
    cyc(); clear_inputs();                                   // N+1
    checks++;
    if (flags() !== 7'b0010000) begin failures++; $display("FAIL sys_flag: got %b required 0010000", flags()); end
    checks++;
    if (exc_pc_o !== 32'h8000_1000 || exc_delayslot_o !== 1'b0) begin
      failures++; $display("FAIL sys_pc: got %h/%b required 80001000/0", exc_pc_o, exc_delayslot_o);
    end
    checks++;
    if ({stall_o, flush_o, redirect_valid_o} !== 3'b110) begin
      failures++; $display("FAIL sys_n1_ctl: got %b required 110", {stall_o, flush_o, redirect_valid_o});
    end
    cyc();                                                   // N+2
    checks++;
    if ({flags(), flush_o, redirect_valid_o} !== 9'b0000000_10) begin
      failures++; $display("FAIL sys_n2: got %b required 000000010", {flags(), flush_o, redirect_valid_o});
    end
    cyc();                                                   // N+3
    checks++;
    if ({flush_o, redirect_valid_o} !== 2'b01 || redirect_pc_o !== VEC) begin
      failures++; $display("FAIL sys_redirect: got %b/%h required 01/%h", {flush_o, redirect_valid_o}, redirect_pc_o, VEC);
    end
    cyc();                                                   // N+4
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL sys_idle: stall=%b required 0", stall_o); end
  endtask

  task automatic test_priority();
    mem_valid_i = 1; mem_overflow_i = 1; mem_break_i = 1; mem_delayslot_i = 1;
    mem_pc_i = 32'h8000_0040;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'b0100000 || exc_delayslot_o !== 1'b1) begin
      failures++; $display("FAIL ovf_brk: got %b ds=%b required 0100000 ds=1", flags(), exc_delayslot_o);
    end
    wait_idle("ovf_brk");
    // eret together with an exception: exception wins, vector target
    mem_valid_i = 1; mem_eret_i = 1; mem_ades_i = 1; cp0_epc_i = 32'h8000_7777;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'b0000010) begin failures++; $display("FAIL eret_vs_ades: got %b required 0000010", flags()); end
    cyc(); cyc();
    checks++;
    if (redirect_pc_o !== VEC) begin failures++; $display("FAIL eret_vs_ades_pc: got %h required %h", redirect_pc_o, VEC); end
    wait_idle("eret_vs_ades");
  endtask

  task automatic test_eret();
    mem_valid_i = 1; mem_eret_i = 1; cp0_epc_i = 32'h8000_2004;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'b0000001) begin failures++; $display("FAIL eret_flag: got %b required 0000001", flags()); end
    cyc(); cyc();
    checks++;
    if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_2004) begin
      failures++; $display("FAIL eret_pc: got %b/%h required 1/80002004", redirect_valid_o, redirect_pc_o);
    end
    wait_idle("eret");
  endtask

  task automatic test_interrupt();
    mem_valid_i = 1; cp0_status_i = 32'h0000_8001; timer_int_i = 1;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'b1000000) begin failures++; $display("FAIL int_flag: got %b required 1000000", flags()); end
    wait_idle("int");
    mem_valid_i = 1; cp0_status_i = 32'h0000_8003; timer_int_i = 1;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'd0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL int_exl_masked: got %b stall=%b required 0000000 stall=0", flags(), stall_o);
    end
  endtask

  task automatic test_backpressure();
    redirect_ready_i = 0;
    mem_valid_i = 1; mem_break_i = 1; mem_pc_i = 32'h8000_0100;
    cyc(); clear_inputs();
    cyc(); cyc();                                            // N+3
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== VEC) begin
        failures++; $display("FAIL bp_hold%0d: got %b/%h required 1/%h", i, redirect_valid_o, redirect_pc_o, VEC);
      end
      cyc();
    end
    redirect_ready_i = 1;
    checks++;
    if (redirect_valid_o !== 1'b1) begin failures++; $display("FAIL bp_handshake: valid=%b required 1", redirect_valid_o); end
    cyc();
    checks++;
    if (stall_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_idle: got %b%b required 00", stall_o, redirect_valid_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    mem_valid_i = 1; mem_adel_i = 1; mem_pc_i = 32'h8000_0200;
    cyc(); clear_inputs();
    cyc();                                                   // FLUSH
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (all_outs() !== 75'd0) begin failures++; $display("FAIL rst_flush: got %h required 0", all_outs()); end
    mem_valid_i = 1; mem_syscall_i = 1; mem_pc_i = 32'h8000_3000;
    cyc(); clear_inputs();
    checks++;
    if (flags() !== 7'b0010000 || exc_pc_o !== 32'h8000_3000) begin
      failures++; $display("FAIL rst_then_sys: got %b/%h required 0010000/80003000", flags(), exc_pc_o);
    end
    wait_idle("rst_then_sys");
  endtask

  // Reference model: an accepted event starts an age count (1 = pulse cycle).
  // Flush covers ages 1..F, redirect is offered from age F+1 until accepted.
  task automatic test_random();
    bit          busy = 0;
    int          age = 0, k = 0;
    logic [31:0] e_pc = 0, e_tgt = 0;
    logic        e_ds = 0;
    logic [6:0]  req, e_flags;
    logic [7:0]  ip;
    logic        pend;
    rst = 1; cyc(); rst = 0;
    for (int c = 0; c < 800; c++) begin
      rst              = ($urandom_range(0, 79) == 0);
      mem_valid_i      = ($urandom_range(0, 3) != 0);
      mem_pc_i         = $urandom;
      mem_delayslot_i  = 1'($urandom);
      mem_syscall_i    = ($urandom_range(0, 7) == 0);
      mem_break_i      = ($urandom_range(0, 7) == 0);
      mem_overflow_i   = ($urandom_range(0, 7) == 0);
      mem_adel_i       = ($urandom_range(0, 7) == 0);
      mem_ades_i       = ($urandom_range(0, 7) == 0);
      mem_eret_i       = ($urandom_range(0, 5) == 0);
      cp0_status_i     = $urandom & 32'h0000_FF03 & ($urandom_range(0, 2) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FF00);
      cp0_cause_i      = $urandom & 32'h0000_0300;
      cp0_epc_i        = $urandom;
      timer_int_i      = ($urandom_range(0, 3) == 0);
      redirect_ready_i = 1'($urandom);
      @(negedge clk);
      e_flags = busy && age == 1 ? (7'b1000000 >> k) : 7'd0;
      checks++;
      if (flags() !== e_flags) begin failures++; $display("FAIL rnd_flags c=%0d: got %b required %b", c, flags(), e_flags); end
      checks++;
      if (exc_pc_o !== (busy && age == 1 ? e_pc : 32'd0) || exc_delayslot_o !== (busy && age == 1 && e_ds)) begin
        failures++; $display("FAIL rnd_excpc c=%0d: got %h/%b required %h/%b", c, exc_pc_o, exc_delayslot_o, e_pc, e_ds);
      end
      checks++;
      if ({stall_o, flush_o, redirect_valid_o} !== {busy, busy && age <= F, busy && age > F}) begin
        failures++; $display("FAIL rnd_ctl c=%0d: got %b required %b", c, {stall_o, flush_o, redirect_valid_o},
                             {busy, busy && age <= F, busy && age > F});
      end
      checks++;
      if (redirect_pc_o !== (busy && age > F ? e_tgt : 32'd0)) begin
        failures++; $display("FAIL rnd_rpc c=%0d: got %h required %h", c, redirect_pc_o, e_tgt);
      end
      // model update with the values the DUT samples at the next edge
      ip   = cp0_cause_i[15:8] | {timer_int_i, 7'b0};
      pend = cp0_status_i[0] && !cp0_status_i[1] && ((ip & cp0_status_i[15:8]) != 8'd0);
      req  = {pend, mem_overflow_i, mem_syscall_i, mem_break_i, mem_adel_i, mem_ades_i, mem_eret_i};
      if (rst) begin
        busy = 0;
      end else if (busy) begin
        if (age > F && redirect_ready_i) busy = 0;
        else age++;
      end else if (mem_valid_i && req != 7'd0) begin
        k = 0;
        while (!req[6 - k]) k++;
        busy  = 1; age = 1;
        e_pc  = mem_pc_i; e_ds = mem_delayslot_i;
        e_tgt = (k == 6) ? cp0_epc_i : VEC;
      end
      cyc();
    end
    rst = 0; clear_inputs(); redirect_ready_i = 1;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_priority();
    test_eret();
    test_interrupt();
    test_backpressure();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
